regfile_wb_arb: RTL

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

---
 rtl/regfile_wb_arb_if.sv | 23 ++
 rtl/regfile_wb_arb.sv | 93 +++++++++
 2 files changed

// File: rtl/regfile_wb_arb_if.sv
// regfile_wb_arb_if: pipeline/async writeback requests and register-file write port of regfile_wb_arb
interface regfile_wb_arb_if;
  logic        m_valid;
  logic [5:0]  m_wbr;
  logic [31:0] m_res;
  logic        a_valid;
  logic [5:0]  a_wbr;
  logic [31:0] a_res;
  logic        a_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        stall_req;
  logic        init_busy;
  modport master (
    output m_valid, m_wbr, m_res, a_valid, a_wbr, a_res,
    input  a_ready, wr_en, wr_addr, wr_data, stall_req, init_busy
  );
  modport slave (
    input  m_valid, m_wbr, m_res, a_valid, a_wbr, a_res,
    output a_ready, wr_en, wr_addr, wr_data, stall_req, init_busy
  );
endinterface

// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb: single-port register-file write arbiter (pipeline commit vs async FIFO); REGFILE_INIT_EN adds a 32-entry zero sweep after reset
module regfile_wb_arb #(
  parameter int STARVE_LIMIT = 8
) (
  input logic             clock,
  input logic             reset_n,
  regfile_wb_arb_if.slave bus
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  logic        run, run_n, live, push, pop, store;
  logic [1:0]  cnt, cnt_n;
  logic [36:0] q0, q1, din, head;
  logic [3:0]  starve;
  logic        a_ready_q, wr_en_q, stall_q;
  logic [4:0]  wr_addr_q, g_addr, sweep;
  logic [31:0] wr_data_q, g_data;
  logic        g_en;
`ifdef REGFILE_INIT_EN
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  // zero-sweep r0..r31 once per reset, then stay in RUN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      sweep <= '0;
    end else if (state == INIT) begin
      sweep <= sweep + 5'd1;
      if (sweep == 5'd31) state <= RUN;
    end
  end
  assign run   = state == RUN;
  assign run_n = run | (sweep == 5'd31);
`else
  assign run   = 1'b1;
  assign run_n = 1'b1;
  assign sweep = '0;
`endif
  // grant: sweep, then live commit, then FIFO head (or bypassed request when the FIFO is empty)
  always_comb begin
    live   = run & bus.m_valid & bus.m_wbr[5] & (|bus.m_wbr[4:0]);
    push   = bus.a_valid & a_ready_q & bus.a_wbr[5] & (|bus.a_wbr[4:0]);
    din    = {bus.a_wbr[4:0], bus.a_res};
    head   = (cnt != 2'd0) ? q0 : din;
    pop    = run & ~live & ((cnt != 2'd0) | push);
    store  = push & ~(pop & (cnt == 2'd0));
    cnt_n  = cnt + {1'b0, push} - {1'b0, pop};
    g_en   = ~run | live | pop;
    g_addr = ~run ? sweep : live ? bus.m_wbr[4:0] : head[36:32];
    g_data = ~run ? 32'd0 : live ? bus.m_res : head[31:0];
  end
  // two-entry async FIFO, q0 is the head
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      q0  <= '0;
      q1  <= '0;
    end else begin
      cnt <= cnt_n;
      q0  <= (store && (cnt == 2'd0 || pop)) ? din : (pop && cnt != 2'd0) ? q1 : q0;
      q1  <= (store && cnt == 2'd1 && !pop) ? din : q1;
    end
  end
  // starvation counter saturating at the limit; stall_req follows it one cycle later
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve  <= '0;
      stall_q <= 1'b0;
    end else begin
      starve  <= (cnt == 2'd0 || pop) ? 4'd0 : (starve == LIM) ? starve : starve + 4'd1;
      stall_q <= (starve == LIM) & ~pop;
    end
  end
  // registered write port and a_ready; address/data hold when idle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_ready_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      a_ready_q <= run_n & (cnt_n != 2'd2);
      wr_en_q   <= g_en;
      wr_addr_q <= g_en ? g_addr : wr_addr_q;
      wr_data_q <= g_en ? g_data : wr_data_q;
    end
  end
  assign bus.a_ready   = a_ready_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.stall_req = stall_q;
  assign bus.init_busy = ~run;
endmodule
